// File: rtl/branch_pkg.sv
// Shared types and helpers for the ID-stage branch resolution controller.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BGEZ = 3'b010,
    BGTZ = 3'b011,
    BLEZ = 3'b100,
    BLTZ = 3'b101
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    RESOLVE  = 2'd2
  } state_e;

  localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [15:0] off;
  } br_req_t;

  function automatic logic is_bad(input logic [2:0] t);
    return t[2] & t[1];
  endfunction

  function automatic logic uses_rt(input logic [2:0] t);
    return (t == BEQ) || (t == BNE);
  endfunction

  // Zero-compare branches never wait on rt.
  function automatic logic ops_ready(input logic [2:0] t, input logic rs_rdy, input logic rt_rdy);
    return rs_rdy & (rt_rdy | ~uses_rt(t));
  endfunction

  function automatic logic [31:0] target(input logic [31:0] pc, input logic [15:0] off);
    return pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode / hazard / fetch-facing signals of the branch controller.
interface branch_ctrl_if #(parameter int CNT_W = 16);
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_type;
  logic [31:0]      br_pc;
  logic [15:0]      br_offset;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             rs_ready;
  logic             rt_ready;
  logic             ex_flush;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             bad_type;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  modport slave (
    input  br_valid, br_type, br_pc, br_offset, rs_val, rt_val, rs_ready, rt_ready, ex_flush,
    output br_ready, stall, redirect_valid, redirect_pc, flush, bad_type, br_total, br_taken
  );

  modport master (
    output br_valid, br_type, br_pc, br_offset, rs_val, rt_val, rs_ready, rt_ready, ex_flush,
    input  br_ready, stall, redirect_valid, redirect_pc, flush, bad_type, br_total, br_taken
  );
endinterface

// File: rtl/branch_ctrl_cmp.sv
// Shared branch comparator; operands arrive sign-flipped so an unsigned compare is signed.
module branch_ctrl_cmp
  import branch_pkg::*;
(
  input  logic [2:0]  branch_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);
  logic eq, lt;

  assign eq = (a == b);
  assign lt = (a < b);

  always_comb begin
    taken = 1'b0;
    case (branch_type)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BGEZ:    taken = ~lt;
      BGTZ:    taken = ~lt & ~eq;
      BLEZ:    taken = lt | eq;
      BLTZ:    taken = lt;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accept, wait for operands, compare, redirect.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  branch_ctrl_if.slave    bus
);
  state_e           state_q, state_d;
  br_req_t          req_q, req_d;
  logic [31:0]      opa_q, opa_d, opb_q, opb_d;
  logic             redir_q, redir_d, bad_q, bad_d;
  logic [31:0]      rpc_q, rpc_d;
  logic [CNT_W-1:0] tot_q, tot_d, tk_q, tk_d;
  logic             accept, taken;

  assign bus.br_ready       = (state_q == IDLE) & ~redir_q & ~bus.ex_flush;
  assign accept             = bus.br_valid & bus.br_ready;
  assign bus.stall          = (state_q != IDLE) | accept;
  assign bus.redirect_valid = redir_q;
  assign bus.flush          = redir_q;
  assign bus.bad_type       = bad_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.br_total       = tot_q;
  assign bus.br_taken       = tk_q;

  branch_ctrl_cmp u_cmp (
    .branch_type (req_q.typ),
    .a           (opa_q ^ SIGN_FLIP),
    .b           (opb_q ^ SIGN_FLIP),
    .taken       (taken)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    redir_d = 1'b0;
    bad_d   = 1'b0;
    rpc_d   = rpc_q;
    tot_d   = tot_q;
    tk_d    = tk_q;
    if (bus.ex_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_d = '{typ: bus.br_type, pc: bus.br_pc, off: bus.br_offset};
          if (is_bad(bus.br_type)) begin
            bad_d = 1'b1;
          end else if (ops_ready(bus.br_type, bus.rs_ready, bus.rt_ready)) begin
            opa_d   = bus.rs_val;
            opb_d   = uses_rt(bus.br_type) ? bus.rt_val : 32'h0;
            state_d = RESOLVE;
          end else begin
            state_d = WAIT_OPS;
          end
        end
        WAIT_OPS: if (ops_ready(req_q.typ, bus.rs_ready, bus.rt_ready)) begin
          opa_d   = bus.rs_val;
          opb_d   = uses_rt(req_q.typ) ? bus.rt_val : 32'h0;
          state_d = RESOLVE;
        end
        RESOLVE: begin
          state_d = IDLE;
          redir_d = taken;
          if (taken) rpc_d = target(req_q.pc, req_q.off);
          tot_d   = tot_q + CNT_W'(1);
          tk_d    = tk_q + CNT_W'(taken);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      redir_q <= 1'b0;
      bad_q   <= 1'b0;
      rpc_q   <= RESET_PC;
      tot_q   <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      redir_q <= redir_d;
      bad_q   <= bad_d;
      rpc_q   <= rpc_d;
      tot_q   <= tot_d;
      tk_q    <= tk_d;
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized scoreboard bench for branch_ctrl; narrow counters make wrap reachable quickly.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int          CNT_W = 6;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(CNT_W)) bus();
  branch_ctrl #(.CNT_W(CNT_W), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int               cyc;
    bit               redir;
    bit               bad;
    logic [31:0]      pc;
    logic [CNT_W-1:0] tot;
    logic [CNT_W-1:0] tk;
  } exp_t;

  exp_t             q[$];
  exp_t             me;
  int               checks = 0, failures = 0, cyc = 0;
  int               stall_seen = 0, stall_exp = 0;
  bit               mon_en = 1'b0;
  logic [31:0]      m_pc = RPC;
  logic [CNT_W-1:0] m_tot = '0, m_tk = '0, prev_tot = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit model_taken(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
    case (t)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) >= 0;
      3'd3:    return $signed(rs) > 0;
      3'd4:    return $signed(rs) <= 0;
      3'd5:    return $signed(rs) < 0;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: any pulse or counter movement is a completion the scoreboard must explain.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.stall) stall_seen++;
      if (bus.redirect_valid || bus.bad_type || bus.br_total !== prev_tot) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d rv=%b bad=%b total=%0d", cyc, bus.redirect_valid, bus.bad_type, bus.br_total);
        end else begin
          me = q.pop_front();
          if (cyc !== me.cyc || bus.redirect_valid !== me.redir || bus.flush !== me.redir ||
              bus.bad_type !== me.bad || bus.redirect_pc !== me.pc ||
              bus.br_total !== me.tot || bus.br_taken !== me.tk) begin
            failures++;
            $display("FAIL completion got cyc=%0d rv=%b fl=%b bad=%b pc=%h tot=%0d tk=%0d want cyc=%0d rv=%b bad=%b pc=%h tot=%0d tk=%0d",
                     cyc, bus.redirect_valid, bus.flush, bus.bad_type, bus.redirect_pc, bus.br_total, bus.br_taken,
                     me.cyc, me.redir, me.bad, me.pc, me.tot, me.tk);
          end
        end
      end
      prev_tot = bus.br_total;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.br_valid = 1'b0;
    bus.ex_flush = 1'b0;
    bus.br_type  = 3'd0;
    bus.br_pc    = $urandom;
    bus.br_offset = 16'($urandom);
    bus.rs_val   = $urandom;
    bus.rt_val   = $urandom;
    bus.rs_ready = 1'($urandom_range(0, 1));
    bus.rt_ready = 1'($urandom_range(0, 1));
  endtask

  // w: cycles the needed operands stay unready; fl: flush cycle offset (-1 none, 0 = accept cycle).
  task automatic run_br(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] off,
                        input logic [31:0] rs, input logic [31:0] rt, input int w, input int fl);
    int k, n;
    bit bad, nrt, tk, rt_late;
    exp_t e;
    k   = cyc;
    bad = (t >= 3'd6);
    nrt = (t < 3'd2);
    tk  = 1'b0;
    if (bad) begin
      n = 1;
      if (fl != 0) begin
        e = '{k + 1, 1'b0, 1'b1, m_pc, m_tot, m_tk};
        q.push_back(e);
        stall_exp += 1;
      end
    end else if (fl == 0) begin
      n = 1;
    end else if (fl > 0) begin
      n = fl + 1;
      stall_exp += fl + 1;
    end else begin
      tk = model_taken(t, rs, rt);
      m_tot = m_tot + 1'b1;
      if (tk) begin
        m_tk = m_tk + 1'b1;
        m_pc = pc + 32'd4 + 32'(int'($signed(off)) * 4);
      end
      e = '{k + w + 2, tk, 1'b0, m_pc, m_tot, m_tk};
      q.push_back(e);
      stall_exp += w + 2;
      n = w + 3;
    end
    rt_late = nrt && (w > 0) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n; i++) begin
      bus.ex_flush = (fl == i);
      if (i == 0) begin
        bus.br_valid = 1'b1; bus.br_type = t; bus.br_pc = pc; bus.br_offset = off;
      end else begin
        bus.br_valid  = (i <= w + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.br_type   = 3'($urandom);
        bus.br_pc     = $urandom;
        bus.br_offset = 16'($urandom);
      end
      if (i < w) begin
        bus.rs_ready = rt_late ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rt_ready = rt_late ? 1'b0 : 1'($urandom_range(0, 1));
        bus.rs_val = $urandom; bus.rt_val = $urandom;
      end else if (i == w) begin
        bus.rs_ready = 1'b1;
        bus.rt_ready = nrt ? 1'b1 : 1'($urandom_range(0, 1));
        bus.rs_val = rs;
        bus.rt_val = nrt ? rt : $urandom;
      end else begin
        bus.rs_ready = 1'($urandom_range(0, 1)); bus.rt_ready = 1'($urandom_range(0, 1));
        bus.rs_val = $urandom; bus.rt_val = $urandom;
      end
      if (i == 0) begin
        #1 chk("br_ready_accept", 32'(bus.br_ready), 32'(fl != 0));
      end else if (!bad && fl < 0 && i == w + 2) begin
        #1 chk("br_ready_redirect", 32'(bus.br_ready), 32'(!tk));
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] rs, rt;
    int          w, fl, sel;
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_br_ready", 32'(bus.br_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_pulses", {29'd0, bus.redirect_valid, bus.flush, bus.bad_type}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, RPC);
    chk("rst_counters", {20'd0, bus.br_total, bus.br_taken}, 32'd0);
    mon_en = 1'b1;
    tick();

    run_br(BEQ,  32'h0000_0100, 16'h0004, 32'd5, 32'd5, 0, -1);
    run_br(BLTZ, 32'h0000_0200, 16'hFFFF, 32'hFFFF_FFFF, 32'd0, 3, -1);
    run_br(BGEZ, 32'h0000_0300, 16'h0010, 32'h8000_0000, 32'd0, 0, -1);
    run_br(BEQ,  32'h0000_0400, 16'h0008, 32'd7, 32'd7, 0, 1);
    run_br(3'b111, 32'h0000_0500, 16'h0000, 32'd0, 32'd0, 0, -1);
    run_br(BNE,  32'h0000_0600, 16'h0001, 32'd1, 32'd2, 0, 0);
    run_br(BGTZ, 32'hFFFF_FFF8, 16'h7FFF, 32'd1, 32'd0, 1, -1);
    run_br(BLEZ, 32'h0000_0700, 16'h8000, 32'd0, 32'd0, 0, -1);

    for (int it = 0; it < 250; it++) begin
      t   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 4);
      rs  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'h8000_0000 : (sel == 2) ? 32'hFFFF_FFFF : $urandom;
      rt  = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      w   = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      fl  = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, w + 1) : -1;
      if (t >= 3'd6) begin
        w = 0;
        if (fl > 0) fl = -1;
      end
      run_br(t, $urandom, 16'($urandom), rs, rt, w, fl);
    end

    repeat (4) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("stall_cycles", 32'(stall_seen), 32'(stall_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
